seq_pattern_gen: RTL

Programmable stimulus generator that drives the four protocol signals `a`, `b`, `c`, `d` consumed by the intersect-operator assertion checkers. One start pulse produces one frame with two lanes that run at the same time:
- Main lane: an `a` burst, a gap, then a `b` burst.
- Side lane: single-cycle `c` pulses with a low cycle between each, then `d` pulses of the same form.

The block sits directly upstream of the checker module. It replaces hand-written negedge stimulus, so pass and fail cases can be swept by changing register values.

---
 rtl/seq_pattern_gen_if.sv | 34 +++
 rtl/seq_pattern_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen_if.sv
// Start/config and pattern/status bundle of seq_pattern_gen.
// The master drives frame requests, the slave produces the pattern.
interface seq_pattern_gen_if #(
  parameter int CW = 4
);
  logic          start;
  logic [CW-1:0] a_len;
  logic [CW-1:0] gap_len;
  logic [CW-1:0] b_len;
  logic [CW-1:0] c_cnt;
  logic [CW-1:0] d_cnt;
  logic          a;
  logic          b;
  logic          c;
  logic          d;
  logic          busy;
  logic          done;
  logic          err;
  logic          trunc;

  modport master (
    output start, a_len, gap_len,
    output b_len, c_cnt, d_cnt,
    input  a, b, c, d,
    input  busy, done, err, trunc
  );

  modport slave (
    input  start, a_len, gap_len,
    input  b_len, c_cnt, d_cnt,
    output a, b, c, d,
    output busy, done, err, trunc
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Frame generator: a/gap/b main lane plus alternating c/d side lane.
// All outputs are registered; config is latched on the accepting edge.
module seq_pattern_gen #(
  parameter int CW = 4
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_gen_if.slave bus
);
  localparam int W = CW + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN_A,
    RUN_GAP,
    RUN_B
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  off_q, off_d;
  logic [CW-1:0] al_q, gl_q, bl_q;
  logic [CW-1:0] cc_q, dc_q;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          c_q, c_d;
  logic          d_q, d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          trunc_q, trunc_d;

  logic          accept;
  logic          run;
  logic          in_frame;
  logic [W-1:0]  al, gl, bl, cc, dc;
  logic [W-1:0]  n, len, ag;
  logic [W-1:0]  c_end, d_end, side_end;

  // On the accepting edge the live inputs describe the frame
  always_comb begin
    accept = (state_q == IDLE) && bus.start
           && (bus.a_len != '0)
           && (bus.b_len != '0);
    al = accept ? W'(bus.a_len)   : W'(al_q);
    gl = accept ? W'(bus.gap_len) : W'(gl_q);
    bl = accept ? W'(bus.b_len)   : W'(bl_q);
    cc = accept ? W'(bus.c_cnt)   : W'(cc_q);
    dc = accept ? W'(bus.d_cnt)   : W'(dc_q);
    ag = al + gl;
    len = ag + bl;
    c_end = cc << 1;
    d_end = c_end + (dc << 1);
    side_end = (dc != '0) ? d_end - W'(1) : c_end;
    n = accept ? '0 : off_q + W'(1);
    run = accept || (state_q != IDLE);
    in_frame = run && (n < len);
  end

  always_comb begin
    state_d = IDLE;
    off_d   = off_q;
    c_d     = 1'b0;
    d_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    trunc_d = trunc_q;
    if (run) off_d = n;
    if (accept) trunc_d = 1'b0;
    if (in_frame) begin
      busy_d = 1'b1;
      unique case (1'b1)
        (n < al):              state_d = RUN_A;
        (n >= al && n < ag):   state_d = RUN_GAP;
        default:               state_d = RUN_B;
      endcase
      c_d = n[0] && (n < c_end);
      d_d = !n[0] && (n >= c_end)
          && (n < d_end);
    end else if (run) begin
      done_d  = 1'b1;
      trunc_d = side_end > len;
    end else if (bus.start) begin
      err_d = 1'b1;
    end
    a_d = (state_d == RUN_A);
    b_d = (state_d == RUN_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      al_q    <= '0;
      gl_q    <= '0;
      bl_q    <= '0;
      cc_q    <= '0;
      dc_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      trunc_q <= trunc_d;
      if (accept) begin
        al_q <= bus.a_len;
        gl_q <= bus.gap_len;
        bl_q <= bus.b_len;
        cc_q <= bus.c_cnt;
        dc_q <= bus.d_cnt;
      end
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.c     = c_q;
  assign bus.d     = d_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.trunc = trunc_q;
endmodule
